// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative shift-add multiply
// and the EX/MEM pipeline register feeding the memory stage.
module ex_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int IMM8_WIDTH = 8,
   parameter int REG_WIDTH  = 4,
   parameter int OP_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] PCE_i,
   input  logic [DATA_WIDTH-1:0] rd1E_i,
   input  logic [DATA_WIDTH-1:0] rd2E_i,
   input  logic [IMM8_WIDTH-1:0] imm8E_i,
   input  logic [REG_WIDTH-1:0]  rsE_i,
   input  logic [REG_WIDTH-1:0]  WriteRegE_i,
   input  logic [OP_WIDTH-1:0]   ALUOpE_i,
   input  logic                  ALUSrcE_i,
   input  logic [5:0]            ctrlE_i,
   input  logic [1:0]            ForwardAE_i,
   input  logic [1:0]            ForwardBE_i,
   input  logic [DATA_WIDTH-1:0] ResultW_i,
   input  logic                  stall_EX_MEM_i,
   input  logic                  flush_EX_MEM_i,
   output logic [ADDR_WIDTH-1:0] PCM_o,
   output logic [DATA_WIDTH-1:0] alu_outM_o,
   output logic [DATA_WIDTH-1:0] WriteDataM_o,
   output logic [IMM8_WIDTH-1:0] imm8M_o,
   output logic [REG_WIDTH-1:0]  rsM_o,
   output logic [REG_WIDTH-1:0]  WriteRegM_o,
   output logic [5:0]            ctrlM_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(8);

   state_t state;

   logic [DATA_WIDTH-1:0] opA;
   logic [DATA_WIDTH-1:0] bFwd;
   logic [DATA_WIDTH-1:0] opB;
   logic [DATA_WIDTH-1:0] immExt;
   logic [DATA_WIDTH-1:0] aluRes;
   logic [DATA_WIDTH-1:0] exRes;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [DATA_WIDTH-1:0] prod;
   logic [3:0]            cnt;
   logic                  isMul;
   logic                  exLoad;
   logic                  exBubble;

   assign isMul  = (ALUOpE_i == OP_MUL);
   assign immExt = {{(DATA_WIDTH-IMM8_WIDTH){imm8E_i[IMM8_WIDTH-1]}},
                    imm8E_i};

   // Forwarding muxes for both register operands
   always_comb begin
      case (ForwardAE_i)
         2'b01:   opA = ResultW_i;
         2'b10:   opA = alu_outM_o;
         default: opA = rd1E_i;
      endcase
      case (ForwardBE_i)
         2'b01:   bFwd = ResultW_i;
         2'b10:   bFwd = alu_outM_o;
         default: bFwd = rd2E_i;
      endcase
      opB = ALUSrcE_i ? immExt : bFwd;
   end

   // Single-cycle ALU; MUL and unused opcodes produce 0 here
   always_comb begin
      aluRes = '0;
      case (ALUOpE_i)
         OP_ADD: aluRes = opA + opB;
         OP_SUB: aluRes = opA - opB;
         OP_AND: aluRes = opA & opB;
         OP_OR:  aluRes = opA | opB;
         OP_XOR: aluRes = opA ^ opB;
         OP_SLL: aluRes = opA << opB[3:0];
         OP_SRL: aluRes = opA >> opB[3:0];
         OP_SLT: aluRes[0] = ($signed(opA) < $signed(opB));
         default: aluRes = '0;
      endcase
   end

   // EX/MEM load control: bubbles while the multiplier owns EX
   always_comb begin
      exLoad   = flush_EX_MEM_i | ~stall_EX_MEM_i;
      exBubble = flush_EX_MEM_i
               | (state == BUSY)
               | ((state == IDLE) & isMul);
      exRes    = (state == DONE) ? prod : aluRes;
   end

   // Hazard unit must freeze upstream while a multiply is issuing/iterating
   always_comb begin
      busy_o = (state == BUSY) | ((state == IDLE) & isMul);
   end

   // Multiply sequencer and shift-add datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
      end else if (flush_EX_MEM_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (isMul && !stall_EX_MEM_i) begin
                  mcand  <= opA;
                  mplier <= opB;
                  prod   <= '0;
                  cnt    <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (mplier[0]) prod <= prod + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 4'd1;
               if (cnt == 4'd15) state <= DONE;
            end
            DONE: begin
               if (!stall_EX_MEM_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PCM_o        <= '0;
         alu_outM_o   <= '0;
         WriteDataM_o <= '0;
         imm8M_o      <= '0;
         rsM_o        <= '0;
         WriteRegM_o  <= '0;
         ctrlM_o      <= '0;
      end else if (exLoad) begin
         if (exBubble) begin
            PCM_o        <= '0;
            alu_outM_o   <= '0;
            WriteDataM_o <= '0;
            imm8M_o      <= '0;
            rsM_o        <= '0;
            WriteRegM_o  <= '0;
            ctrlM_o      <= '0;
         end else begin
            PCM_o        <= PCE_i;
            alu_outM_o   <= exRes;
            WriteDataM_o <= bFwd;
            imm8M_o      <= imm8E_i;
            rsM_o        <= rsE_i;
            WriteRegM_o  <= WriteRegE_i;
            ctrlM_o      <= ctrlE_i;
         end
      end
   end

endmodule
